// File: rtl/sound_frame_seq_if.sv
// Sound register bus and channel-timer control outputs of sound_frame_seq.
// The master side (CPU/register file) drives apu_en and the write bus; the
// slave side (frame sequencer) drives strobes, triggers and length reloads.
// div_tick is only present when SOUND_FS_EXT_TICK_EN is defined.
//
// Write bus semantics: reg_wr is a one-cycle strobe with no back-pressure.
// reg_addr/reg_din are sampled on the same rising edge as reg_wr=1, and the
// slave always accepts the write (there is no ready signal).
interface sound_frame_seq_if;
    logic       apu_en;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_din;
`ifdef SOUND_FS_EXT_TICK_EN
    logic       div_tick;
`endif
    logic       clk_len;
    logic       clk_sweep;
    logic       clk_env;
    logic [2:0] fs_step;
    logic [3:0] start;
    logic [3:0] single;
    logic [5:0] len1;
    logic [5:0] len2;
    logic [5:0] len4;
    logic [7:0] len3;

`ifdef SOUND_FS_EXT_TICK_EN
    modport master (
        output apu_en, reg_wr, reg_addr, reg_din, div_tick,
        input  clk_len, clk_sweep, clk_env, fs_step, start, single,
               len1, len2, len3, len4
    );
    modport slave (
        input  apu_en, reg_wr, reg_addr, reg_din, div_tick,
        output clk_len, clk_sweep, clk_env, fs_step, start, single,
               len1, len2, len3, len4
    );
`else
    modport master (
        output apu_en, reg_wr, reg_addr, reg_din,
        input  clk_len, clk_sweep, clk_env, fs_step, start, single,
               len1, len2, len3, len4
    );
    modport slave (
        input  apu_en, reg_wr, reg_addr, reg_din,
        output clk_len, clk_sweep, clk_env, fs_step, start, single,
               len1, len2, len3, len4
    );
`endif
endinterface

// File: rtl/sound_frame_seq.sv
// APU frame sequencer and NRx1/NRx4 decode.
// A 512 Hz frame tick advances an 8-step sequencer that emits the 256 Hz
// length, 128 Hz sweep and 64 Hz envelope strobes one cycle after the tick.
// Writes to NR11/21/31/41 produce length-counter reload values and writes to
// NR14/24/34/44 produce per-channel length-enable levels and trigger pulses.
// While apu_en is low every register is held at zero.
//
// Configuration macro SOUND_FS_EXT_TICK_EN: when defined the internal
// CLK_DIV divider is removed and frame ticks come from bus.div_tick.
// The sequencer step (fs_step) is the only piece of control state and is
// exported directly for observation.
module sound_frame_seq #(
    parameter int CLK_DIV = 8192
) (
    input logic              clk,
    input logic              rst,
    sound_frame_seq_if.slave bus
);

    localparam logic [7:0] ADDR_NR11 = 8'h11;
    localparam logic [7:0] ADDR_NR21 = 8'h16;
    localparam logic [7:0] ADDR_NR31 = 8'h1B;
    localparam logic [7:0] ADDR_NR41 = 8'h20;
    localparam logic [7:0] ADDR_NR14 = 8'h14;
    localparam logic [7:0] ADDR_NR24 = 8'h19;
    localparam logic [7:0] ADDR_NR34 = 8'h1E;
    localparam logic [7:0] ADDR_NR44 = 8'h23;

    logic       frame_tick;

    logic [2:0] step_q, step_d;
    logic       clk_len_q, clk_len_d;
    logic       clk_sweep_q, clk_sweep_d;
    logic       clk_env_q, clk_env_d;

    logic [3:0] start_q, start_d;
    logic [3:0] single_q, single_d;
    logic [5:0] len1_q, len1_d;
    logic [5:0] len2_q, len2_d;
    logic [5:0] len4_q, len4_d;
    logic [7:0] len3_q, len3_d;

`ifdef SOUND_FS_EXT_TICK_EN
    // External 512 Hz tick; only counts while the APU is powered.
    always_comb begin
        frame_tick = bus.apu_en & bus.div_tick;
    end
`else
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // Divider next state: count 0..CLK_DIV-1, tick on the wrap, clear when off.
    always_comb begin
        div_d      = div_q;
        frame_tick = 1'b0;
        if (!bus.apu_en) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d      = '0;
            frame_tick = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`endif

    // Sequencer next state: on a tick, decode the current step into strobes
    // and advance. Strobes default low so each one lasts exactly one cycle.
    always_comb begin
        step_d      = step_q;
        clk_len_d   = 1'b0;
        clk_sweep_d = 1'b0;
        clk_env_d   = 1'b0;
        if (!bus.apu_en) begin
            step_d = 3'd0;
        end else if (frame_tick) begin
            clk_len_d   = ~step_q[0];
            clk_sweep_d = (step_q[1:0] == 2'd2);
            clk_env_d   = (step_q == 3'd7);
            step_d      = step_q + 3'd1;
        end
    end

    // Sequencer step and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q      <= 3'd0;
            clk_len_q   <= 1'b0;
            clk_sweep_q <= 1'b0;
            clk_env_q   <= 1'b0;
        end else begin
            step_q      <= step_d;
            clk_len_q   <= clk_len_d;
            clk_sweep_q <= clk_sweep_d;
            clk_env_q   <= clk_env_d;
        end
    end

    // Register decode: length reloads are stored as (max - written length)
    // because the channel counters count down to zero. Triggers are single
    // cycle pulses, so back-to-back writes give back-to-back pulses.
    always_comb begin
        start_d  = 4'b0000;
        single_d = single_q;
        len1_d   = len1_q;
        len2_d   = len2_q;
        len3_d   = len3_q;
        len4_d   = len4_q;
        if (!bus.apu_en) begin
            single_d = 4'b0000;
            len1_d   = 6'd0;
            len2_d   = 6'd0;
            len3_d   = 8'd0;
            len4_d   = 6'd0;
        end else if (bus.reg_wr) begin
            case (bus.reg_addr)
                ADDR_NR11: len1_d = 6'd63 - bus.reg_din[5:0];
                ADDR_NR21: len2_d = 6'd63 - bus.reg_din[5:0];
                ADDR_NR41: len4_d = 6'd63 - bus.reg_din[5:0];
                ADDR_NR31: len3_d = 8'd255 - bus.reg_din;
                ADDR_NR14: begin
                    single_d[0] = bus.reg_din[6];
                    start_d[0]  = bus.reg_din[7];
                end
                ADDR_NR24: begin
                    single_d[1] = bus.reg_din[6];
                    start_d[1]  = bus.reg_din[7];
                end
                ADDR_NR34: begin
                    single_d[2] = bus.reg_din[6];
                    start_d[2]  = bus.reg_din[7];
                end
                ADDR_NR44: begin
                    single_d[3] = bus.reg_din[6];
                    start_d[3]  = bus.reg_din[7];
                end
                default: ;
            endcase
        end
    end

    // Decoded register outputs; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 4'b0000;
            single_q <= 4'b0000;
            len1_q   <= 6'd0;
            len2_q   <= 6'd0;
            len3_q   <= 8'd0;
            len4_q   <= 6'd0;
        end else begin
            start_q  <= start_d;
            single_q <= single_d;
            len1_q   <= len1_d;
            len2_q   <= len2_d;
            len3_q   <= len3_d;
            len4_q   <= len4_d;
        end
    end

    assign bus.clk_len   = clk_len_q;
    assign bus.clk_sweep = clk_sweep_q;
    assign bus.clk_env   = clk_env_q;
    assign bus.fs_step   = step_q;
    assign bus.start     = start_q;
    assign bus.single    = single_q;
    assign bus.len1      = len1_q;
    assign bus.len2      = len2_q;
    assign bus.len3      = len3_q;
    assign bus.len4      = len4_q;

endmodule
